// File: rtl/encoder_pkg.sv
// encoder_pkg
//   Shared definitions for the quadrature encoder controller: the decoder
//   state enumeration (encodings are visible on the currState debug port),
//   the rest level of the debounced XY pair, and default parameter values.
package encoder_pkg;

  localparam int unsigned WIDTH_DEF    = 8;
  localparam int unsigned DEBOUNCE_DEF = 4;

  // Both channels high is the detent (rest) position.
  localparam logic [1:0] REST_LVL = 2'b11;

  typedef enum logic [2:0] {
    ST_REST  = 3'd0,
    ST_CW_A  = 3'd1,  // XY = 01
    ST_CW_B  = 3'd2,  // XY = 00
    ST_CW_C  = 3'd3,  // XY = 10
    ST_CCW_A = 3'd4,  // XY = 10
    ST_CCW_B = 3'd5,  // XY = 00
    ST_CCW_C = 3'd6,  // XY = 01
    ST_ERR   = 3'd7
  } enc_state_e;

endpackage

// File: rtl/enc_debounce.sv
// enc_debounce
//   Two-flop synchronizer followed by a stability filter for one raw
//   encoder channel. The filtered value only takes a new level after the
//   synchronized input has disagreed with it for DEBOUNCE consecutive
//   cycles; any return to the current level restarts the count.
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset (all stages reset to 1)
//   raw_in  - raw channel input, asynchronous to clk
//   deb_out - debounced channel level
module enc_debounce
  import encoder_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic deb_out
);

  localparam logic [7:0] DEB_LIMIT = 8'(DEBOUNCE);

  logic       sync1_q;
  logic       sync2_q;
  logic       deb_q;
  logic       deb_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] cnt_inc_s;

  // Stability counter: counts cycles of disagreement, commits on reaching the limit.
  always_comb begin
    cnt_inc_s = cnt_q + 8'd1;
    deb_d     = deb_q;
    cnt_d     = 8'd0;
    if (sync2_q != deb_q) begin
      if (cnt_inc_s >= DEB_LIMIT) begin
        deb_d = sync2_q;
        cnt_d = 8'd0;
      end else begin
        cnt_d = cnt_inc_s;
      end
    end else begin
      cnt_d = 8'd0;
    end
  end

  // Synchronizer and filter registers; reset to the high (rest) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_out = deb_q;

endmodule

// File: rtl/encoder_controller.sv
// encoder_controller
//   Quadrature encoder front end: debounces both channels, tracks the
//   XY phase sequence of one detent through a decoder FSM, and keeps a
//   wrapping signed detent count.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   encInput_X/Y   - raw quadrature channels (asynchronous)
//   clear          - synchronous zero of position and errorFlag
//   position       - signed detent count, wraps modulo 2^WIDTH
//   stepValid      - one-cycle pulse per completed detent
//   stepDir        - direction of the last step (1 = CW, 0 = CCW)
//   errorFlag      - sticky illegal-transition flag
//   currState      - decoder state encoding for debug
module encoder_controller
  import encoder_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    encInput_X,
  input  logic                    encInput_Y,
  input  logic                    clear,
  output logic signed [WIDTH-1:0] position,
  output logic                    stepValid,
  output logic                    stepDir,
  output logic                    errorFlag,
  output logic [2:0]              currState
);

  localparam logic signed [WIDTH-1:0] POS_ZERO = {WIDTH{1'b0}};
  localparam logic signed [WIDTH-1:0] POS_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic                    deb_x_s;
  logic                    deb_y_s;
  logic [1:0]              xy_s;
  enc_state_e              state_q;
  enc_state_e              state_d;
  logic signed [WIDTH-1:0] position_q;
  logic signed [WIDTH-1:0] position_d;
  logic                    step_valid_q;
  logic                    step_valid_d;
  logic                    step_dir_q;
  logic                    step_dir_d;
  logic                    error_q;
  logic                    error_d;
  logic                    step_cw_s;
  logic                    step_ccw_s;
  logic                    err_entry_s;

  enc_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_x (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_in  (encInput_X),
    .deb_out (deb_x_s)
  );

  enc_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_y (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_in  (encInput_Y),
    .deb_out (deb_y_s)
  );

  assign xy_s = {deb_x_s, deb_y_s};

  // Decoder next state; a step is flagged only on the *_C -> REST edge.
  always_comb begin
    state_d    = state_q;
    step_cw_s  = 1'b0;
    step_ccw_s = 1'b0;
    case (state_q)
      ST_REST: begin
        case (xy_s)
          2'b01:   state_d = ST_CW_A;
          2'b10:   state_d = ST_CCW_A;
          2'b00:   state_d = ST_ERR;
          default: state_d = state_q;
        endcase
      end
      ST_CW_A: begin
        case (xy_s)
          2'b00:   state_d = ST_CW_B;
          2'b11:   state_d = ST_REST;
          2'b10:   state_d = ST_ERR;
          default: state_d = state_q;
        endcase
      end
      ST_CW_B: begin
        case (xy_s)
          2'b10:   state_d = ST_CW_C;
          2'b01:   state_d = ST_CW_A;
          2'b11:   state_d = ST_ERR;
          default: state_d = state_q;
        endcase
      end
      ST_CW_C: begin
        case (xy_s)
          2'b11: begin
            state_d   = ST_REST;
            step_cw_s = 1'b1;
          end
          2'b00:   state_d = ST_CW_B;
          2'b01:   state_d = ST_ERR;
          default: state_d = state_q;
        endcase
      end
      ST_CCW_A: begin
        case (xy_s)
          2'b00:   state_d = ST_CCW_B;
          2'b11:   state_d = ST_REST;
          2'b01:   state_d = ST_ERR;
          default: state_d = state_q;
        endcase
      end
      ST_CCW_B: begin
        case (xy_s)
          2'b01:   state_d = ST_CCW_C;
          2'b10:   state_d = ST_CCW_A;
          2'b11:   state_d = ST_ERR;
          default: state_d = state_q;
        endcase
      end
      ST_CCW_C: begin
        case (xy_s)
          2'b11: begin
            state_d    = ST_REST;
            step_ccw_s = 1'b1;
          end
          2'b00:   state_d = ST_CCW_B;
          2'b10:   state_d = ST_ERR;
          default: state_d = state_q;
        endcase
      end
      ST_ERR: begin
        if (xy_s == REST_LVL) begin
          state_d = ST_REST;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_REST;
    endcase
  end

  // Output values for the next cycle; clear beats a step on position but
  // loses to a fresh error entry on errorFlag.
  always_comb begin
    err_entry_s  = (state_d == ST_ERR) && (state_q != ST_ERR);
    step_valid_d = step_cw_s | step_ccw_s;

    if (step_cw_s) begin
      step_dir_d = 1'b1;
    end else if (step_ccw_s) begin
      step_dir_d = 1'b0;
    end else begin
      step_dir_d = step_dir_q;
    end

    if (clear) begin
      position_d = POS_ZERO;
    end else if (step_cw_s) begin
      position_d = position_q + POS_ONE;
    end else if (step_ccw_s) begin
      position_d = position_q - POS_ONE;
    end else begin
      position_d = position_q;
    end

    if (err_entry_s) begin
      error_d = 1'b1;
    end else if (clear) begin
      error_d = 1'b0;
    end else begin
      error_d = error_q;
    end
  end

  // Decoder state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_REST;
      position_q   <= POS_ZERO;
      step_valid_q <= 1'b0;
      step_dir_q   <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      position_q   <= position_d;
      step_valid_q <= step_valid_d;
      step_dir_q   <= step_dir_d;
      error_q      <= error_d;
    end
  end

  assign position  = position_q;
  assign stepValid = step_valid_q;
  assign stepDir   = step_dir_q;
  assign errorFlag = error_q;
  assign currState = state_q;

endmodule

// File: tb/tb_encoder_controller.sv
// tb_encoder_controller
//   Scoreboard bench for encoder_controller. The reference model tracks the
//   quadrature phase displacement since the last rest position (+1 per CW
//   quarter, -1 per CCW quarter, a half-cycle jump is illegal); a detent is
//   counted when the displacement reaches +/-4. Expected step events are
//   queued when stimulus is issued and popped by a monitor on each pulse.
`timescale 1ns/1ps
module tb_encoder_controller;

  localparam int WIDTH    = 8;
  localparam int DEBOUNCE = 4;
  localparam int STEP_LAT = DEBOUNCE + 2;  // negedges from drive to the edge that updates the FSM
  localparam int HOLD     = 10;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic enc_x = 1'b1;
  logic enc_y = 1'b1;
  logic clear = 1'b0;
  logic signed [WIDTH-1:0] position;
  logic stepValid;
  logic stepDir;
  logic errorFlag;
  logic [2:0] currState;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic             dir;
    logic [WIDTH-1:0] pos;
  } step_ev_t;

  step_ev_t exp_q[$];
  step_ev_t mon_ev;

  // Reference model state
  logic [1:0]       m_lvl;
  int               m_disp;
  bit               m_in_err;
  logic [WIDTH-1:0] m_pos;
  bit               m_err;
  bit               m_dir;

  encoder_controller #(.WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .encInput_X (enc_x),
    .encInput_Y (enc_y),
    .clear      (clear),
    .position   (position),
    .stepValid  (stepValid),
    .stepDir    (stepDir),
    .errorFlag  (errorFlag),
    .currState  (currState)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Quadrature phase index along the CW direction: 11,01,00,10.
  function automatic int phase_idx(input logic [1:0] xy);
    case (xy)
      2'b11:   return 0;
      2'b01:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] phase_lvl(input int idx);
    case (idx)
      0:       return 2'b11;
      1:       return 2'b01;
      2:       return 2'b00;
      default: return 2'b10;
    endcase
  endfunction

  function automatic void model_reset();
    m_lvl    = 2'b11;
    m_disp   = 0;
    m_in_err = 1'b0;
    m_pos    = '0;
    m_err    = 1'b0;
    m_dir    = 1'b0;
    exp_q.delete();
  endfunction

  // New debounced level arrives; clr means clear coincides with its effect.
  function automatic void model_level(input logic [1:0] xy, input bit clr);
    int delta;
    bit entered;
    bit stepped;
    bit sdir;
    entered = 1'b0;
    stepped = 1'b0;
    sdir    = 1'b0;
    if (xy != m_lvl) begin
      if (m_in_err) begin
        if (xy == 2'b11) begin
          m_in_err = 1'b0;
          m_disp   = 0;
        end
      end else begin
        delta = (phase_idx(xy) - phase_idx(m_lvl) + 4) % 4;
        if (delta == 2) begin
          entered  = 1'b1;
          m_disp   = 0;
          m_in_err = (xy != 2'b11);  // an illegal jump onto 11 leaves ERR right away
        end else begin
          m_disp += (delta == 1) ? 1 : -1;
          if (m_disp == 4 || m_disp == -4) begin
            stepped = 1'b1;
            sdir    = (m_disp == 4);
            m_disp  = 0;
          end
        end
      end
      m_lvl = xy;
    end
    if (stepped) begin
      m_dir = sdir;
      if (!clr) m_pos = sdir ? m_pos + ONE : m_pos - ONE;
    end
    if (clr) m_pos = '0;
    if (entered) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if (stepped) exp_q.push_back({sdir, m_pos});
  endfunction

  function automatic int exp_state();
    if (m_in_err) return 7;
    if (m_disp > 0) return m_disp;
    if (m_disp < 0) return 3 - m_disp;
    return 0;
  endfunction

  task automatic check_settled(input string tag);
    logic [WIDTH-1:0] p;
    p = position;
    check({tag, ".state"}, int'(currState), exp_state());
    check({tag, ".position"}, int'(p), int'(m_pos));
    check({tag, ".errorFlag"}, int'(errorFlag), int'(m_err));
    check({tag, ".stepDir"}, int'(stepDir), int'(m_dir));
  endtask

  // mode 0: no clear, 1: clear pulse at end of hold, 2: clear on the FSM update edge
  task automatic apply_level(input logic [1:0] xy, input int hold, input int mode, input string tag);
    enc_x = xy[1];
    enc_y = xy[0];
    if (mode == 2) begin
      model_level(xy, 1'b1);
      repeat (STEP_LAT) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      repeat (hold - STEP_LAT - 1) @(negedge clk);
    end else begin
      model_level(xy, 1'b0);
      repeat (hold - 1) @(negedge clk);
      if (mode == 1) begin
        clear = 1'b1;
        m_pos = '0;
        m_err = 1'b0;
      end
      @(negedge clk);
      clear = 1'b0;
    end
    check_settled(tag);
  endtask

  task automatic glitch(input logic [1:0] xy, input int len, input string tag);
    enc_x = xy[1];
    enc_y = xy[0];
    repeat (len) @(negedge clk);
    enc_x = m_lvl[1];
    enc_y = m_lvl[0];
    repeat (HOLD) @(negedge clk);
    check_settled(tag);
  endtask

  task automatic cw_detent(input int last_mode, input string tag);
    apply_level(2'b01, HOLD, 0, tag);
    apply_level(2'b00, HOLD, 0, tag);
    apply_level(2'b10, HOLD, 0, tag);
    apply_level(2'b11, HOLD, last_mode, tag);
  endtask

  task automatic ccw_detent(input string tag);
    apply_level(2'b10, HOLD, 0, tag);
    apply_level(2'b00, HOLD, 0, tag);
    apply_level(2'b01, HOLD, 0, tag);
    apply_level(2'b11, HOLD, 0, tag);
  endtask

  // Reset with inputs optionally left where they are.
  task automatic do_reset(input bit keep_inputs, input string tag);
    logic [WIDTH-1:0] p;
    rst_n = 1'b0;
    clear = 1'b0;
    if (!keep_inputs) begin
      enc_x = 1'b1;
      enc_y = 1'b1;
    end
    repeat (3) @(negedge clk);
    p = position;
    check({tag, ".rst_position"}, int'(p), 0);
    check({tag, ".rst_stepValid"}, int'(stepValid), 0);
    check({tag, ".rst_stepDir"}, int'(stepDir), 0);
    check({tag, ".rst_errorFlag"}, int'(errorFlag), 0);
    check({tag, ".rst_state"}, int'(currState), 0);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: every stepValid pulse must match the oldest queued step.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && stepValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_step: stepValid=1 dir=%0d pos=%0d, expected no pulse (t=%0t)",
                 stepDir, $unsigned(position), $time);
      end else begin
        mon_ev = exp_q.pop_front();
        check("step.dir", int'(stepDir), int'(mon_ev.dir));
        check("step.position", int'($unsigned(position)), int'(mon_ev.pos));
      end
    end
  end

  initial begin
    int r;
    int cur;
    model_reset();
    do_reset(1'b0, "reset");

    // One CW detent: 0 -> 1
    cw_detent(0, "cw1");

    // Two CCW detents from reset: 0 -> 0xFF -> 0xFE
    do_reset(1'b0, "reset2");
    ccw_detent("ccw1");
    ccw_detent("ccw2");

    // Short glitch on X at rest
    glitch(2'b01, 2, "glitch_x");

    // Illegal jump, recovery without step, then clear
    apply_level(2'b00, HOLD, 0, "err_entry");
    apply_level(2'b11, HOLD, 0, "err_exit");
    apply_level(2'b11, HOLD, 1, "err_clear");

    // Error entry coincident with clear leaves the flag set
    apply_level(2'b00, HOLD, 2, "err_clear_same");
    apply_level(2'b11, HOLD, 1, "err_clear2");

    // Partial CW with backtrack: no step
    apply_level(2'b01, HOLD, 0, "back_a");
    apply_level(2'b00, HOLD, 0, "back_b");
    apply_level(2'b01, HOLD, 0, "back_a2");
    apply_level(2'b11, HOLD, 0, "back_rest");

    // Randomized walk: mostly legal quarter steps, some jumps, glitches, clears
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      cur = phase_idx(m_lvl);
      if (r == 0) begin
        glitch(phase_lvl((cur + $urandom_range(1, 3)) % 4), $urandom_range(1, DEBOUNCE - 1), "rnd_glitch");
      end else if (r == 1) begin
        apply_level(2'($urandom_range(0, 3)), HOLD + $urandom_range(0, 4), 0, "rnd_jump");
      end else begin
        apply_level(phase_lvl((cur + ((r < 6) ? 1 : 3)) % 4), HOLD + $urandom_range(0, 4),
                    ($urandom_range(0, 7) == 0) ? 1 : 0, "rnd_quad");
      end
    end
    apply_level(2'b11, HOLD, 0, "rnd_home");

    // Wrap: 127 CW steps to 0x7F, one more to 0x80, back to 0x7F,
    // then a CW step coincident with clear
    do_reset(1'b0, "reset3");
    for (int i = 0; i < 127; i++) cw_detent(0, "preset");
    cw_detent(0, "wrap_up");
    ccw_detent("wrap_down");
    cw_detent(2, "clear_step");

    // Reset in the middle of a detent, released with inputs at 00
    apply_level(2'b01, HOLD, 0, "mid_a");
    apply_level(2'b00, HOLD, 0, "mid_b");
    do_reset(1'b1, "mid_reset");
    apply_level(2'b00, HOLD, 0, "after_reset");
    apply_level(2'b11, HOLD, 0, "after_reset_rest");

    repeat (5) @(negedge clk);
    check("pending_steps", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/encoder_controller.md
ENCODER_CONTROLLER -- requirements
Module: encoder_controller

Interface
REQ-001 Parameter WIDTH, default 8: position counter width in bits, two's complement.
REQ-002 Parameter DEBOUNCE, default 4: consecutive stable cycles required before an input change is accepted; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 encInput_X  input  1  raw quadrature channel X, asynchronous to clk.
REQ-006 encInput_Y  input  1  raw quadrature channel Y, asynchronous to clk.
REQ-007 clear  input  1  synchronous; zeroes position and errorFlag.
REQ-008 position  output  WIDTH  signed detent count.
REQ-009 stepValid  output  1  one-cycle pulse per completed detent.
REQ-010 stepDir  output  1  direction of the last step: 1 = CW, 0 = CCW.
REQ-011 errorFlag  output  1  sticky illegal-transition indicator.
REQ-012 currState  output  3  decoder state encoding, for debug.

Function
REQ-013 Each channel passes through a 2-flop synchronizer, then a debouncer; a debounced value changes only after the synchronized value differs from it for DEBOUNCE consecutive cycles; any glitch restarts the count.
REQ-014 The decoder FSM samples the debounced pair XY; the rest level is XY=11.
REQ-015 States: REST, CW_A(01), CW_B(00), CW_C(10), CCW_A(10), CCW_B(00), CCW_C(01), ERR; the encodings are 0..7 in that order.
REQ-016 REST: on 01 go to CW_A; on 10 go to CCW_A; on 00 go to ERR.
REQ-017 CW_A: on 00 go to CW_B; on 11 go to REST with no step; on 10 go to ERR.
REQ-018 CW_B: on 10 go to CW_C; on 01 go to CW_A; on 11 go to ERR.
REQ-019 CW_C: on 11 go to REST and issue a CW step; on 00 go to CW_B; on 01 go to ERR.
REQ-020 The CCW states mirror the CW states with X and Y swapped; CCW_C on 11 goes to REST and issues a CCW step.
REQ-021 ERR: stay in ERR until XY=11, then go to REST; no step is issued on that exit.
REQ-022 An unchanged XY holds the current state.
REQ-023 A step appears in the same cycle the state register becomes REST from *_C: stepValid=1 for exactly one cycle, stepDir updated, and position already updated.
REQ-024 A CW step adds 1 to position and a CCW step subtracts 1; arithmetic wraps modulo 2^WIDTH (0x7F+1 -> 0x80; 0x00-1 -> 0xFF).
REQ-025 Every entry into ERR sets errorFlag; errorFlag holds until clear or reset.
REQ-026 If clear and a step occur in the same cycle, clear wins: position=0 and the step is not counted, but stepValid and stepDir still report the step.
REQ-027 If clear coincides with an ERR entry, errorFlag ends the cycle at 1.
REQ-028 clear does not affect FSM state or the debouncers.
REQ-029 stepDir holds its value between steps.
REQ-030 Worst-case latency from a raw input edge to the FSM state update is 2 + DEBOUNCE + 1 cycles.

Reset
REQ-031 While rst_n=0: state=REST, position=0, stepValid=0, stepDir=0, errorFlag=0, and synchronizer/debounced values=1 so that release at rest produces no transition.
REQ-032 Reset asserted mid-detent discards the partial detent; after release, the FSM starts from REST regardless of input level.

Structure
REQ-033 Package encoder_pkg holds the state enum, the REST level constant, and the default WIDTH/DEBOUNCE values.
REQ-034 One sub-module, enc_debounce (synchronizer plus stability counter, parameter DEBOUNCE), is instantiated once per channel.
REQ-035 The FSM next-state logic and the position counter live in encoder_controller.

Verification
REQ-036 Full CW sequence 11->01->00->10->11, each level held 10 cycles, DEBOUNCE=4 -> one stepValid pulse, stepDir=1, position 0->1.
REQ-037 Two full CCW sequences from reset -> two pulses, stepDir=0, position 0->0xFF->0xFE.
REQ-038 A 2-cycle glitch on X at rest -> no state change, no pulse, position unchanged.
REQ-039 11->00 direct jump -> ERR, errorFlag=1; return to 11 -> REST with no step; clear -> errorFlag=0.
REQ-040 CW to CW_B, back to CW_A, then 11 -> no step; position unchanged.
REQ-041 Position preset to 0x7F via 127 CW steps, then clear coincident with the 128th step -> position=0, stepValid=1; separately, rst_n low at CW_B -> all outputs at reset values.
